// File: rtl/rgb_led_pkg.sv
// -----------------------------------------------------------------------------
// rgb_led_pkg
// Shared types and constants for the RGB LED fade driver.
//   state_t   : fade sequencer states (IDLE, FADE_OUT, SWAP, FADE_IN)
//   COLOR_*   : 3-bit colour codes, bit order {B,G,R}
// -----------------------------------------------------------------------------
package rgb_led_pkg;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_FADE_OUT = 2'd1,
        ST_SWAP     = 2'd2,
        ST_FADE_IN  = 2'd3
    } state_t;

    localparam logic [2:0] COLOR_OFF = 3'b000;
    localparam logic [2:0] COLOR_R   = 3'b001;
    localparam logic [2:0] COLOR_G   = 3'b010;
    localparam logic [2:0] COLOR_B   = 3'b100;
    localparam logic [2:0] COLOR_W   = 3'b111;

endpackage

// File: rtl/rgb_pwm_timebase.sv
// -----------------------------------------------------------------------------
// rgb_pwm_timebase
// Free-running PWM counter plus a period counter that produces the fade
// step tick.
//   clk         : system clock
//   rst         : asynchronous active-high reset
//   i_hold      : hold the period counter at 0 (sequencer in IDLE or SWAP)
//   o_cnt       : PWM counter, 0 .. 2^PWM_W-1, wraps
//   o_wrap      : high in the cycle where o_cnt is at its maximum
//   o_step_tick : wrap that completes STEP_PERIODS PWM periods
// -----------------------------------------------------------------------------
module rgb_pwm_timebase #(
    parameter int PWM_W        = 8,
    parameter int STEP_PERIODS = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_hold,
    output logic [PWM_W-1:0] o_cnt,
    output logic             o_wrap,
    output logic             o_step_tick
);

    // One bit minimum so STEP_PERIODS=1 still yields a legal vector.
    localparam int              PER_W    = (STEP_PERIODS > 1) ? $clog2(STEP_PERIODS) : 1;
    localparam logic [PER_W-1:0] PER_LAST = PER_W'(STEP_PERIODS - 1);

    logic [PWM_W-1:0] r_cnt;
    logic [PER_W-1:0] r_per_cnt;

    assign o_cnt       = r_cnt;
    assign o_wrap      = (r_cnt == {PWM_W{1'b1}});
    assign o_step_tick = o_wrap && (r_per_cnt == PER_LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt     <= '0;
            r_per_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + 1'b1;
            if (i_hold) begin
                r_per_cnt <= '0;
            end else if (o_wrap) begin
                r_per_cnt <= (r_per_cnt == PER_LAST) ? '0 : r_per_cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/rgb_led_fade_driver.sv
// -----------------------------------------------------------------------------
// rgb_led_fade_driver
// Drives two RGB LEDs with PWM brightness; every colour/level change runs as
// fade-out -> colour swap -> fade-in so the LEDs never jump colour abruptly.
// Optional feature macro: RGB_BLINK_EN (adds blink_in / BLINK_PERIODS; while
// idle with blink_in=1 the outputs are blanked every other blink phase).
//   clk        : system clock
//   rst        : asynchronous active-high reset
//   load       : request colour/level change, taken only while ready=1
//   color_4_in : new colour for LED 4 ({B,G,R})
//   color_5_in : new colour for LED 5 ({B,G,R})
//   level_in   : target brightness
//   blink_in   : blink enable (RGB_BLINK_EN only)
//   ready      : high while idle
//   led_out_4  : registered PWM-gated RGB pins, LED 4
//   led_out_5  : registered PWM-gated RGB pins, LED 5
// -----------------------------------------------------------------------------
module rgb_led_fade_driver
    import rgb_led_pkg::*;
#(
    parameter int PWM_W         = 8,
    parameter int STEP_PERIODS  = 4,
`ifdef RGB_BLINK_EN
    parameter int BLINK_PERIODS = 64,
`endif
    parameter int FADE_STEP     = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [2:0]       color_4_in,
    input  logic [2:0]       color_5_in,
    input  logic [PWM_W-1:0] level_in,
`ifdef RGB_BLINK_EN
    input  logic             blink_in,
`endif
    output logic             ready,
    output logic [2:0]       led_out_4,
    output logic [2:0]       led_out_5
);

    localparam logic [PWM_W:0] STEP_X = (PWM_W+1)'(FADE_STEP);

    state_t           r_state;
    logic [PWM_W-1:0] r_bright;
    logic [PWM_W-1:0] r_target;
    logic [2:0]       r_col_4;
    logic [2:0]       r_col_5;
    logic [2:0]       r_pend_4;
    logic [2:0]       r_pend_5;

    logic [PWM_W-1:0] w_cnt;
    logic             w_wrap;
    logic             w_step_tick;
    logic             w_step;
    logic             w_on;
    logic             w_blank;
    logic [PWM_W:0]   w_sum;
    logic [PWM_W:0]   w_diff;
    logic [PWM_W-1:0] w_dn;
    logic [PWM_W-1:0] w_up;

    rgb_pwm_timebase #(
        .PWM_W        (PWM_W),
        .STEP_PERIODS (STEP_PERIODS)
    ) u_tb (
        .clk         (clk),
        .rst         (rst),
        .i_hold      ((r_state == ST_IDLE) || (r_state == ST_SWAP)),
        .o_cnt       (w_cnt),
        .o_wrap      (w_wrap),
        .o_step_tick (w_step_tick)
    );

    // The step tick is always a wrap; the AND keeps "brightness only moves
    // at a period boundary" visible at the point of use.
    assign w_step = w_wrap & w_step_tick;
    assign w_on   = (w_cnt < r_bright);

    // Saturating fade arithmetic in PWM_W+1 bits.
    assign w_diff = {1'b0, r_bright} - STEP_X;
    assign w_dn   = ({1'b0, r_bright} > STEP_X) ? w_diff[PWM_W-1:0] : '0;
    assign w_sum  = {1'b0, r_bright} + STEP_X;
    assign w_up   = (w_sum > {1'b0, r_target}) ? r_target : w_sum[PWM_W-1:0];

`ifdef RGB_BLINK_EN
    localparam int               BL_W    = (BLINK_PERIODS > 1) ? $clog2(BLINK_PERIODS) : 1;
    localparam logic [BL_W-1:0]  BL_LAST = BL_W'(BLINK_PERIODS - 1);

    logic [BL_W-1:0] r_blink_cnt;
    logic            r_blink_phase;

    // Phase 0 = visible, phase 1 = blanked; restarts whenever blink drops.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_blink_cnt   <= '0;
            r_blink_phase <= 1'b0;
        end else if (!blink_in) begin
            r_blink_cnt   <= '0;
            r_blink_phase <= 1'b0;
        end else if (w_wrap) begin
            if (r_blink_cnt == BL_LAST) begin
                r_blink_cnt   <= '0;
                r_blink_phase <= ~r_blink_phase;
            end else begin
                r_blink_cnt <= r_blink_cnt + 1'b1;
            end
        end
    end

    assign w_blank = blink_in & r_blink_phase & (r_state == ST_IDLE);
`else
    assign w_blank = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= ST_IDLE;
            r_bright  <= '0;
            r_target  <= '0;
            r_col_4   <= '0;
            r_col_5   <= '0;
            r_pend_4  <= '0;
            r_pend_5  <= '0;
            ready     <= 1'b1;
            led_out_4 <= '0;
            led_out_5 <= '0;
        end else begin
            led_out_4 <= w_blank ? 3'b000 : (r_col_4 & {3{w_on}});
            led_out_5 <= w_blank ? 3'b000 : (r_col_5 & {3{w_on}});

            case (r_state)
                ST_IDLE: begin
                    if (load) begin
                        r_pend_4 <= color_4_in;
                        r_pend_5 <= color_5_in;
                        r_target <= level_in;
                        r_state  <= ST_FADE_OUT;
                        ready    <= 1'b0;
                    end
                end
                ST_FADE_OUT: begin
                    if (r_bright == '0) begin
                        r_state <= ST_SWAP;
                    end else if (w_step) begin
                        r_bright <= w_dn;
                    end
                end
                ST_SWAP: begin
                    // Brightness is 0 here, so the colour change is invisible.
                    r_col_4 <= r_pend_4;
                    r_col_5 <= r_pend_5;
                    r_state <= ST_FADE_IN;
                end
                ST_FADE_IN: begin
                    if (r_bright == r_target) begin
                        r_state <= ST_IDLE;
                        ready   <= 1'b1;
                    end else if (w_step) begin
                        r_bright <= w_up;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    ready   <= 1'b1;
                end
            endcase
        end
    end

endmodule
